// File: rtl/rupt_sequencer.sv
// Interrupt arbiter and entry sequencer: latches requests, waits for a legal
// instruction boundary, then flushes decode, saves ZRUPT and redirects fetch.
module rupt_sequencer #(
  parameter int          N_RUPT   = 10,
  parameter logic [11:0] VEC_BASE = 12'o4000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_RUPT-1:0] rupt_req,
  input  logic              inhint,
  input  logic              relint,
  input  logic              resume,
  input  logic              extend_pend,
  input  logic              index_pend,
  input  logic              ovf_a,
  input  logic              stall,
  input  logic              valid_D,
  input  logic [11:0]       pc_D,
  output logic              flush,
  output logic              stall_F,
  output logic              save_en,
  output logic [11:0]       save_pc,
  output logic              vec_valid,
  output logic [11:0]       vec_pc,
  output logic              in_rupt,
  output logic [N_RUPT-1:0] pending,
  output logic [3:0]        active_id
);

  typedef enum logic [1:0] {IDLE, FLUSH, VECTOR, SERVE} state_t;

  state_t            state, state_next;
  logic              inhibit;
  logic              eligible;
  logic              take;
  logic [3:0]        grant_id;
  logic [N_RUPT-1:0] grant_clr;

  // Lowest pending index wins; scanning downward leaves the lowest one last.
  always_comb begin
    grant_id  = '0;
    grant_clr = '0;
    for (int i = N_RUPT - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grant_id  = 4'(i);
        grant_clr = '0;
        grant_clr[i] = 1'b1;
      end
    end
  end

  assign eligible = (|pending) & ~inhibit & ~in_rupt & ~extend_pend & ~index_pend
                    & ~ovf_a & ~stall & valid_D;

  always_comb begin
    state_next = state;
    take       = 1'b0;
    flush      = 1'b0;
    stall_F    = 1'b0;
    save_en    = 1'b0;
    vec_valid  = 1'b0;
    vec_pc     = '0;
    in_rupt    = 1'b0;
    case (state)
      IDLE: begin
        if (eligible) begin
          take       = 1'b1;
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        flush      = 1'b1;
        stall_F    = 1'b1;
        save_en    = 1'b1;
        in_rupt    = 1'b1;
        state_next = VECTOR;
      end
      VECTOR: begin
        vec_valid  = 1'b1;
        vec_pc     = VEC_BASE + {6'd0, active_id, 2'b00} + 12'd4;
        in_rupt    = 1'b1;
        state_next = SERVE;
      end
      SERVE: begin
        in_rupt = 1'b1;
        if (resume) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A request arriving in the same cycle its bit is granted stays pending.
  // Decode is flushed outside IDLE, so INHINT/RELINT only count in IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= '0;
      inhibit   <= 1'b1;
      active_id <= '0;
      save_pc   <= '0;
    end else begin
      state   <= state_next;
      pending <= (pending & ~(take ? grant_clr : '0)) | rupt_req;
      if (state == IDLE) begin
        if (inhint)      inhibit <= 1'b1;
        else if (relint) inhibit <= 1'b0;
      end
      if (take) begin
        active_id <= grant_id;
        save_pc   <= pc_D;
      end
    end
  end

endmodule

// File: tb/tb_rupt_sequencer.sv
// Table-driven bench for rupt_sequencer: each vector drives one cycle and the
// expected post-edge outputs go through a scoreboard queue.
module tb_rupt_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  rupt_req;
  logic        inhint, relint, resume, extend_pend, index_pend, ovf_a, stall, valid_D;
  logic [11:0] pc_D;
  logic        flush, stall_F, save_en, vec_valid, in_rupt;
  logic [11:0] save_pc, vec_pc;
  logic [9:0]  pending;
  logic [3:0]  active_id;

  int tests = 0;
  int fails = 0;

  rupt_sequencer dut (
    .clock(clock), .reset(reset), .rupt_req(rupt_req), .inhint(inhint),
    .relint(relint), .resume(resume), .extend_pend(extend_pend),
    .index_pend(index_pend), .ovf_a(ovf_a), .stall(stall), .valid_D(valid_D),
    .pc_D(pc_D), .flush(flush), .stall_F(stall_F), .save_en(save_en),
    .save_pc(save_pc), .vec_valid(vec_valid), .vec_pc(vec_pc),
    .in_rupt(in_rupt), .pending(pending), .active_id(active_id)
  );

  always #5 clock = ~clock;

  localparam logic [7:0] VLD = 8'h01, STL = 8'h02, OVF = 8'h04, IDX = 8'h08,
                         EXT = 8'h10, RES = 8'h20, REL = 8'h40, INH = 8'h80;
  localparam logic [2:0] F = 3'b100, V = 3'b010, R = 3'b001;

  typedef struct {
    logic        rst;
    logic [9:0]  req;
    logic [7:0]  ctl;
    logic [11:0] pc;
    logic [42:0] exp_out;
  } vec_t;

  vec_t        tbl[$];
  logic [42:0] exp_q[$];

  function automatic vec_t v(logic rst, logic [9:0] req, logic [7:0] ctl, logic [11:0] pc,
                             logic [2:0] fvr, logic [11:0] vpc, logic [9:0] pend,
                             logic [11:0] spc, logic [3:0] aid);
    vec_t t;
    t.rst = rst;
    t.req = req;
    t.ctl = ctl;
    t.pc  = pc;
    t.exp_out = {fvr[2], fvr[2], fvr[2], fvr[1], vpc, fvr[0], pend, spc, aid};
    return t;
  endfunction

  task automatic applyStimulus(input vec_t t);
    reset       = t.rst;
    rupt_req    = t.req;
    {inhint, relint, resume, extend_pend, index_pend, ovf_a, stall, valid_D} = t.ctl;
    pc_D        = t.pc;
    exp_q.push_back(t.exp_out);
  endtask

  task automatic checkOutput(input string name);
    logic [42:0] act, expv;
    act  = {flush, stall_F, save_en, vec_valid, vec_pc, in_rupt, pending, save_pc, active_id};
    expv = exp_q.pop_front();
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  initial begin
    int cycles;
    reset = 1'b1; rupt_req = '0; pc_D = '0;
    {inhint, relint, resume, extend_pend, index_pend, ovf_a, stall, valid_D} = '0;

    // reset state
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0));
    // relint + req[2], then entry at pc 2345
    tbl.push_back(v(0, 10'h004, REL|VLD, 12'o2345, 0, 0, 10'h004, 0, 0));
    tbl.push_back(v(0, 0, VLD, 12'o2345, F|R, 0, 0, 12'o2345, 2));
    tbl.push_back(v(0, 0, VLD, 12'o2345, V|R, 12'o4014, 0, 12'o2345, 2));
    tbl.push_back(v(0, 0, VLD, 12'o2345, R, 0, 0, 12'o2345, 2));
    tbl.push_back(v(0, 0, RES|VLD, 12'o2345, 0, 0, 0, 12'o2345, 2));
    // two simultaneous requests: id 2 first, then id 4 after resume
    tbl.push_back(v(0, 10'h014, VLD, 12'o1000, 0, 0, 10'h014, 12'o2345, 2));
    tbl.push_back(v(0, 0, VLD, 12'o1000, F|R, 0, 10'h010, 12'o1000, 2));
    tbl.push_back(v(0, 0, VLD, 12'o1000, V|R, 12'o4014, 10'h010, 12'o1000, 2));
    tbl.push_back(v(0, 0, VLD, 12'o1000, R, 0, 10'h010, 12'o1000, 2));
    tbl.push_back(v(0, 0, VLD, 12'o1000, R, 0, 10'h010, 12'o1000, 2));
    tbl.push_back(v(0, 0, RES|VLD, 12'o1000, 0, 0, 10'h010, 12'o1000, 2));
    tbl.push_back(v(0, 0, VLD, 12'o1100, F|R, 0, 0, 12'o1100, 4));
    tbl.push_back(v(0, 0, VLD, 12'o1100, V|R, 12'o4024, 0, 12'o1100, 4));
    tbl.push_back(v(0, 0, VLD, 12'o1100, R, 0, 0, 12'o1100, 4));
    tbl.push_back(v(0, 0, RES|VLD, 12'o1100, 0, 0, 0, 12'o1100, 4));
    // extend_pend holds off for 3 cycles
    tbl.push_back(v(0, 10'h001, EXT|VLD, 12'o0123, 0, 0, 10'h001, 12'o1100, 4));
    tbl.push_back(v(0, 0, EXT|VLD, 12'o0123, 0, 0, 10'h001, 12'o1100, 4));
    tbl.push_back(v(0, 0, EXT|VLD, 12'o0123, 0, 0, 10'h001, 12'o1100, 4));
    tbl.push_back(v(0, 0, VLD, 12'o0123, F|R, 0, 0, 12'o0123, 0));
    tbl.push_back(v(0, 0, VLD, 12'o0123, V|R, 12'o4004, 0, 12'o0123, 0));
    tbl.push_back(v(0, 0, VLD, 12'o0123, R, 0, 0, 12'o0123, 0));
    tbl.push_back(v(0, 0, RES|VLD, 12'o0123, 0, 0, 0, 12'o0123, 0));
    // index_pend holds off one cycle
    tbl.push_back(v(0, 10'h001, IDX|VLD, 12'o0200, 0, 0, 10'h001, 12'o0123, 0));
    tbl.push_back(v(0, 0, VLD, 12'o0200, F|R, 0, 0, 12'o0200, 0));
    tbl.push_back(v(0, 0, VLD, 12'o0200, V|R, 12'o4004, 0, 12'o0200, 0));
    tbl.push_back(v(0, 0, VLD, 12'o0200, R, 0, 0, 12'o0200, 0));
    tbl.push_back(v(0, 0, RES|VLD, 12'o0200, 0, 0, 0, 12'o0200, 0));
    // inhint+relint together -> inhibited; relint alone -> grant
    tbl.push_back(v(0, 0, INH|REL|VLD, 12'o0400, 0, 0, 0, 12'o0200, 0));
    tbl.push_back(v(0, 10'h008, VLD, 12'o0400, 0, 0, 10'h008, 12'o0200, 0));
    tbl.push_back(v(0, 0, VLD, 12'o0400, 0, 0, 10'h008, 12'o0200, 0));
    tbl.push_back(v(0, 0, REL|VLD, 12'o0400, 0, 0, 10'h008, 12'o0200, 0));
    tbl.push_back(v(0, 0, VLD, 12'o0400, F|R, 0, 0, 12'o0400, 3));
    tbl.push_back(v(0, 0, VLD, 12'o0400, V|R, 12'o4020, 0, 12'o0400, 3));
    tbl.push_back(v(0, 0, VLD, 12'o0400, R, 0, 0, 12'o0400, 3));
    // request during SERVE only latches; re-entry after resume
    tbl.push_back(v(0, 10'h001, VLD, 12'o0400, R, 0, 10'h001, 12'o0400, 3));
    tbl.push_back(v(0, 0, VLD, 12'o0400, R, 0, 10'h001, 12'o0400, 3));
    tbl.push_back(v(0, 0, RES|VLD, 12'o0400, 0, 0, 10'h001, 12'o0400, 3));
    tbl.push_back(v(0, 0, VLD, 12'o0500, F|R, 0, 0, 12'o0500, 0));
    // reset in VECTOR clears everything and re-inhibits
    tbl.push_back(v(0, 10'h020, VLD, 12'o0500, V|R, 12'o4004, 10'h020, 12'o0500, 0));
    tbl.push_back(v(1, 0, VLD, 12'o0500, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 10'h002, VLD, 12'o0600, 0, 0, 10'h002, 0, 0));
    tbl.push_back(v(0, 0, VLD, 12'o0600, 0, 0, 10'h002, 0, 0));
    tbl.push_back(v(0, 0, REL|VLD, 12'o0600, 0, 0, 10'h002, 0, 0));
    tbl.push_back(v(0, 0, VLD, 12'o0600, F|R, 0, 0, 12'o0600, 1));
    tbl.push_back(v(0, 0, VLD, 12'o0600, V|R, 12'o4010, 0, 12'o0600, 1));
    tbl.push_back(v(0, 0, VLD, 12'o0600, R, 0, 0, 12'o0600, 1));
    tbl.push_back(v(0, 0, RES|VLD, 12'o0600, 0, 0, 0, 12'o0600, 1));
    // stall, !valid_D, ovf_a each block; resume in IDLE is harmless
    tbl.push_back(v(0, 10'h001, RES|STL|VLD, 12'o0700, 0, 0, 10'h001, 12'o0600, 1));
    tbl.push_back(v(0, 0, 0, 12'o0700, 0, 0, 10'h001, 12'o0600, 1));
    tbl.push_back(v(0, 0, OVF|VLD, 12'o0700, 0, 0, 10'h001, 12'o0600, 1));
    tbl.push_back(v(0, 0, VLD, 12'o0700, F|R, 0, 0, 12'o0700, 0));
    tbl.push_back(v(0, 0, VLD, 12'o0700, V|R, 12'o4004, 0, 12'o0700, 0));
    tbl.push_back(v(0, 0, VLD, 12'o0700, R, 0, 0, 12'o0700, 0));
    tbl.push_back(v(0, 0, RES|VLD, 12'o0700, 0, 0, 0, 12'o0700, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      @(posedge clock);
      #1;
      checkOutput($sformatf("vec%0d", i));
    end

    // latency from eligible cycle to vec_valid, bounded wait
    applyStimulus(v(1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clock); #1;
    checkOutput("lat_reset");
    applyStimulus(v(0, 10'h080, REL|VLD, 12'o0777, 0, 0, 10'h080, 0, 0));
    @(posedge clock); #1;
    checkOutput("lat_latch");
    {inhint, relint, resume, extend_pend, index_pend, ovf_a, stall, valid_D} = VLD;
    rupt_req = '0;
    cycles = 0;
    while (vec_valid !== 1'b1 && cycles < 10) begin
      @(posedge clock); #1;
      cycles++;
    end
    check_val("lat_cycles", 32'(cycles), 32'd2);
    check_val("lat_vec_pc", {20'd0, vec_pc}, {20'd0, 12'o4040});
    check_val("lat_save_pc", {20'd0, save_pc}, {20'd0, 12'o0777});
    check_val("lat_id", {28'd0, active_id}, 32'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
